// File: rtl/axi4lite_reg_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave:
// response codes, FSM state encodings and the byte-lane merge.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned CTL_REG_INDEX_DEFAULT = 5;

    typedef enum logic [1:0] {
        W_IDLE,
        W_CAPTURE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int unsigned i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle (five channels) with master and slave views.
interface axi4lite_reg_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file slave: NUM_REGS words, top word is a live read-only
// status, one word drives ctl_value with a one-cycle write strobe.
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned CTL_REG_INDEX  = CTL_REG_INDEX_DEFAULT
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    axi4lite_reg_slave_if.slave   s_axi,
    input  logic [31:0]           status_in,
    output logic [31:0]           ctl_value,
    output logic                  ctl_strobe
);

    localparam logic [10:0] NUM_REGS_W = 11'(NUM_REGS);
    localparam logic [9:0]  STATUS_IDX = 10'(NUM_REGS - 1);
    localparam logic [9:0]  CTL_IDX    = 10'(CTL_REG_INDEX);

    // Storage excludes the STATUS word, which has no backing register.
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS-1];

    wr_state_t                   w_state, w_state_n;
    logic                        awready_q, awready_n, wready_q, wready_n;
    logic                        bvalid_q, bvalid_n;
    logic [1:0]                  bresp_q, bresp_n;
    logic                        aw_have, aw_have_n, w_have, w_have_n;
    logic [9:0]                  aw_idx, aw_idx_n;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_n;
    logic                        commit, wr_ok, aw_hs, w_hs;

    rd_state_t                   r_state, r_state_n;
    logic                        arready_q, arready_n, rvalid_q, rvalid_n;
    logic [1:0]                  rresp_q, rresp_n;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_n, rd_word;
    logic [9:0]                  ar_idx;
    logic                        rd_ok, ar_hs;

    logic                        unused_bits;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[AXI_ADDR_WIDTH-1:12], s_axi.awaddr[1:0],
                           s_axi.araddr[AXI_ADDR_WIDTH-1:12], s_axi.araddr[1:0]};

    assign aw_hs  = s_axi.awvalid && awready_q;
    assign w_hs   = s_axi.wvalid && wready_q;
    assign ar_hs  = s_axi.arvalid && arready_q;
    assign ar_idx = s_axi.araddr[11:2];
    assign wr_ok  = ({1'b0, aw_idx} < NUM_REGS_W) && (aw_idx != STATUS_IDX);
    assign rd_ok  = ({1'b0, ar_idx} < NUM_REGS_W);

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign ctl_value     = regs[CTL_REG_INDEX];

    // IDLE and CAPTURE share logic: each channel is taken independently and
    // its READY stays high until its own handshake.
    always_comb begin
        w_state_n = w_state;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        aw_have_n = aw_have;
        w_have_n  = w_have;
        aw_idx_n  = aw_idx;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        commit    = 1'b0;
        case (w_state)
            W_IDLE, W_CAPTURE: begin
                if (aw_hs) begin
                    aw_have_n = 1'b1;
                    aw_idx_n  = s_axi.awaddr[11:2];
                    awready_n = 1'b0;
                end else if (!aw_have) begin
                    awready_n = 1'b1;
                end
                if (w_hs) begin
                    w_have_n = 1'b1;
                    wdata_n  = s_axi.wdata;
                    wstrb_n  = s_axi.wstrb;
                    wready_n = 1'b0;
                end else if (!w_have) begin
                    wready_n = 1'b1;
                end
                if (aw_have_n && w_have_n) begin
                    w_state_n = W_COMMIT;
                end else if (aw_have_n || w_have_n) begin
                    w_state_n = W_CAPTURE;
                end
            end
            W_COMMIT: begin
                commit    = 1'b1;
                bvalid_n  = 1'b1;
                bresp_n   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                w_state_n = W_RESP;
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    aw_have_n = 1'b0;
                    w_have_n  = 1'b0;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state    <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            aw_have    <= 1'b0;
            w_have     <= 1'b0;
            aw_idx     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ctl_strobe <= 1'b0;
        end else begin
            w_state    <= w_state_n;
            awready_q  <= awready_n;
            wready_q   <= wready_n;
            bvalid_q   <= bvalid_n;
            bresp_q    <= bresp_n;
            aw_have    <= aw_have_n;
            w_have     <= w_have_n;
            aw_idx     <= aw_idx_n;
            wdata_q    <= wdata_n;
            wstrb_q    <= wstrb_n;
            ctl_strobe <= commit && wr_ok && (aw_idx == CTL_IDX);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (aw_idx == 10'(i)) begin
                    regs[i] <= byte_merge(regs[i], wdata_q, wstrb_q);
                end
            end
        end
    end

    // Out-of-range indices match nothing and fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (ar_idx == 10'(i)) begin
                rd_word = regs[i];
            end
        end
        if (ar_idx == STATUS_IDX) begin
            rd_word = status_in;
        end
    end

    always_comb begin
        r_state_n = r_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rresp_n   = rresp_q;
        rdata_n   = rdata_q;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_word;
                    rresp_n   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_n = R_RESP;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: a vector table of single transfers
// plus hand-timed sequences for channel ordering, back-pressure and reset.
module tb_axi4lite_reg_slave;
    import axi4lite_pkg::*;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] status;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] status_in = '0;
    logic [31:0] ctl_value;
    logic        ctl_strobe;
    int          vectors = 0;
    int          miscompares = 0;
    int          bcount = 0;

    axi4lite_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4lite_reg_slave #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .NUM_REGS(16),
        .CTL_REG_INDEX(5)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(bus),
        .status_in(status_in),
        .ctl_value(ctl_value),
        .ctl_strobe(ctl_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.bvalid && bus.bready) bcount <= bcount + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            tick();
            if (aw_f) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_f)  begin bus.wvalid = 1'b0;  w_done = 1;  end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!(aw_done && w_done)) expire("aw_w");
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 0;
        resp = 2'bxx;
        bus.bready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.bvalid) begin
                resp = bus.bresp;
                got = 1;
            end
            tick();
        end
        bus.bready = 1'b0;
        if (!got) expire("b");
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done = 0, f;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            f = bus.arvalid && bus.arready;
            tick();
            if (f) done = 1;
        end
        bus.arvalid = 1'b0;
        if (!done) expire("ar");
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
        bit got = 0;
        data = 'x; resp = 2'bxx;
        bus.rready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.rvalid) begin
                data = bus.rdata; resp = bus.rresp;
                got = 1;
            end
            tick();
        end
        bus.rready = 1'b0;
        if (!got) expire("r");
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bus.bready = 1'b0;
        send_aw_w(a, d, s);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
        send_ar(a);
        wait_r(data, resp);
    endtask

    // One channel goes first, the other follows three cycles later.
    task automatic split_write(input logic [31:0] a, input logic [31:0] d, input bit aw_first);
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [1:0]  rr;
        int          b0;
        bus.bready = 1'b0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
        if (aw_first) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
        tick();
        chk("first_ready_drop", {31'd0, aw_first ? bus.awready : bus.wready}, 32'd0);
        chk("other_ready_held", {31'd0, aw_first ? bus.wready : bus.awready}, 32'd1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (3) begin
            tick();
            chk("gap_bvalid", {31'd0, bus.bvalid}, 32'd0);
        end
        if (aw_first) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("second_ready_drop", {30'd0, bus.awready, bus.wready}, 32'd0);
        chk("commit_bvalid_low", {31'd0, bus.bvalid}, 32'd0);
        b0 = bcount;
        wait_b(resp);
        chk("split_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        bus.bready = 1'b1;
        tick(); tick();
        bus.bready = 1'b0;
        chk("split_one_b", bcount - b0, 32'd1);
        axi_read(a, rd, rr);
        chk("split_readback", rd, d);
    endtask

    vec_t        tbl [19];
    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        tbl = '{
            '{1'b1, 32'h0000_1000, 32'h1122_3344, 4'hF, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b1, 32'h0000_1000, 32'hAABB_CCDD, 4'h5, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'h11BB_33DD},
            '{1'b1, 32'h0000_1000, 32'h1122_3344, 4'hF, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b1, 32'h0000_1000, 32'hAABB_CCDD, 4'h4, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'h11BB_3344},
            '{1'b1, 32'h0000_103C, 32'hFFFF_FFFF, 4'hF, 32'h0,         RESP_SLVERR, 32'h0},
            '{1'b1, 32'h0000_1040, 32'h1234_5678, 4'hF, 32'h0,         RESP_SLVERR, 32'h0},
            '{1'b0, 32'h0000_1040, 32'h0,         4'h0, 32'h0000_1234, RESP_SLVERR, 32'h0},
            '{1'b0, 32'h0000_103C, 32'h0,         4'h0, 32'h0000_1234, RESP_OKAY,   32'h0000_1234},
            '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h0, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b1, 32'h0000_2007, 32'hCAFE_F00D, 4'hF, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'hCAFE_F00D},
            '{1'b1, 32'h0000_1038, 32'h0BAD_F00D, 4'hF, 32'h0,         RESP_OKAY,   32'h0},
            '{1'b0, 32'h0000_F038, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'h0BAD_F00D},
            '{1'b0, 32'h0000_13FC, 32'h0,         4'h0, 32'h0,         RESP_SLVERR, 32'h0},
            '{1'b0, 32'h0000_103C, 32'h0,         4'h0, 32'hA5A5_0000, RESP_OKAY,   32'hA5A5_0000},
            '{1'b0, 32'h0000_1014, 32'h0,         4'h0, 32'h0,         RESP_OKAY,   32'h0000_0042}
        };

        #3;
        chk("rst_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        chk("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
        chk("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_ctl", {ctl_value[30:0], ctl_strobe}, 32'd0);
        #9 rst_n = 1'b1;
        #1 chk("pre_edge_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);

        // Simultaneous AW/W to the control register, edge by edge.
        bus.awaddr = 32'h1014; bus.wdata = 32'h42; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("ctl_e1_readys", {30'd0, bus.awready, bus.wready}, 32'd0);
        chk("ctl_e1_bvalid", {31'd0, bus.bvalid}, 32'd0);
        chk("ctl_e1_strobe", {31'd0, ctl_strobe}, 32'd0);
        tick();
        chk("ctl_e2_bvalid", {31'd0, bus.bvalid}, 32'd1);
        chk("ctl_e2_bresp", {30'd0, bus.bresp}, {30'd0, RESP_OKAY});
        chk("ctl_e2_strobe", {31'd0, ctl_strobe}, 32'd1);
        chk("ctl_e2_value", ctl_value, 32'h42);
        tick();
        bus.bready = 1'b0;
        chk("ctl_e3_bvalid", {31'd0, bus.bvalid}, 32'd0);
        chk("ctl_e3_strobe", {31'd0, ctl_strobe}, 32'd0);
        chk("ctl_e3_readys", {30'd0, bus.awready, bus.wready}, 32'd3);
        axi_read(32'h1014, rd, resp);
        chk("ctl_readback", rd, 32'h42);

        split_write(32'h1008, 32'h0000_5555, 1'b0);
        split_write(32'h1008, 32'h6666_0000, 1'b1);

        for (int i = 0; i < 19; i++) begin
            status_in = tbl[i].status;
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp);
                chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, tbl[i].exp_resp});
            end else begin
                axi_read(tbl[i].addr, rd, resp);
                chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, tbl[i].exp_resp});
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_data);
            end
        end

        // B and R back-pressure.
        bus.bready = 1'b0;
        send_aw_w(32'h1010, 32'h77, 4'hF);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", {31'd0, bus.bvalid}, 32'd1);
            chk("bp_bresp", {30'd0, bus.bresp}, {30'd0, RESP_OKAY});
            chk("bp_readys", {30'd0, bus.awready, bus.wready}, 32'd0);
            tick();
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bp_b_done", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'd3);
        bus.rready = 1'b0;
        send_ar(32'h1010);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", {30'd0, bus.rvalid, bus.arready}, 32'd2);
            chk("bp_rdata", bus.rdata, 32'h77);
            chk("bp_rresp", {30'd0, bus.rresp}, {30'd0, RESP_OKAY});
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("bp_r_done", {30'd0, bus.rvalid, bus.arready}, 32'd1);

        // Reset while a write response is pending.
        send_aw_w(32'h1018, 32'h99, 4'hF);
        tick();
        chk("pre_rst_bvalid", {31'd0, bus.bvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
        chk("arst_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        chk("arst_ctl", ctl_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_edge_readys", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
        axi_read(32'h1000, rd, resp);
        chk("rst_reg0", rd, 32'd0);
        axi_read(32'h1018, rd, resp);
        chk("rst_aborted_write", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
